mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Load/store unit for the MEM stage. It consumes the instruction, address and store data held in the EX/MEM pipeline register and performs the data-memory access over a valid/ready request channel plus a response channel. It stalls the pipeline until the access completes and returns sign- or zero-extended load data for the MEM/WB register. Misaligned or illegal accesses are flagged and are never issued.

## Interface
Parameters:
- none (RV32 data path, 32-bit word-addressed memory port, fixed)

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  reset, synchronous, active-high
- MEM_valid  in  1  MEM stage holds a real instruction (0 = bubble)
- MEM_inst  in  32  instruction; opcode [6:0], funct3 [14:12]
- MEM_alu_res  in  32  effective byte address
- MEM_rs2_val  in  32  store source value
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte-lane strobes (0000 for loads)
- dmem_resp_valid  in  1  load data returned
- dmem_rdata  in  32  returned word
- mem_stall  out  1  hold IF..EX/MEM registers
- mem_fault  out  1  misaligned or illegal funct3 access
- load_data  out  32  extended load result

## Operation
- Decode: load = MEM_valid & opcode 7'b0000011; store = MEM_valid & opcode 7'b0100011; mem_op = load|store.
- Legal funct3 values: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- Fault = mem_op & (illegal funct3 | halfword with addr[0]≠0 | word with addr[1:0]≠0). mem_fault is combinational. A faulting op issues no request and does not stall.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on mem_op & ~fault, register addr/we/wdata/wstrb/funct3/addr[1:0] and go to REQ.
  - REQ: dmem_req_valid=1. On req_ready, a store goes to DONE and a load goes to WAIT.
  - WAIT: on resp_valid, capture the extended result into load_data and go to DONE.
  - DONE: go to IDLE.
- mem_stall = mem_op & ~fault & (state≠DONE). This is combinational, so it is high in the IDLE cycle of a new op.
- Store data:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001<<addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011<<addr[1:0].
  - SW: wdata = rs2, wstrb = 1111.
- Load extract: select byte addr[1:0] or halfword addr[1] from rdata. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- load_data holds its value until the next load completes.
- dmem_resp_valid outside WAIT is ignored.

## Timing
- Reset values:
  - state IDLE
  - dmem_req_valid 0
  - dmem_we 0
  - dmem_addr 0
  - dmem_wdata 0
  - dmem_wstrb 0
  - load_data 0
- The request payload is stable for every cycle dmem_req_valid=1. valid never drops before ready.
- A response is accepted no earlier than the cycle after the request handshake.
- Zero-wait memory (ready=1, resp one cycle after handshake):
  - Load: IDLE, REQ, WAIT, DONE. That is 4 MEM cycles with 3 stall cycles.
  - Store: IDLE, REQ, DONE. That is 3 MEM cycles with 2 stall cycles.
- In DONE, mem_stall=0, so the pipeline advances at the end of DONE. load_data is valid in the DONE cycle.
- Back-to-back mem ops: the next op is seen in IDLE the cycle after DONE. No op is issued twice.
- MEM_* inputs are stable while mem_stall=1, because the upstream registers are held.
- rst in any state forces IDLE and drops dmem_req_valid in the following cycle. An in-flight response is discarded.
- Bubble (MEM_valid=0) or non-memory op: stall 0, state stays IDLE, no request.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF, ready=1: req 1 cycle after op; load_data=0xDEADBEEF in DONE; stall high exactly 3 cycles.
- LB at 0x103 with rdata=0x80FF_1234 → 0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU at 0x102 → 0x0000_80FF.
- SB rs2=0x000000AB at 0x201: addr=0x200, wdata=0xABABABAB, wstrb=0010, we=1. SH at 0x202: wstrb=1100. Stall high exactly 2 cycles.
- Backpressure: req_ready low for 5 cycles, then high. req_valid and payload are held constant for all 6 cycles; exactly one handshake occurs.
- LW at 0x102, and funct3=011 load: mem_fault=1, no req_valid, stall=0.
- rst asserted in WAIT, then resp_valid the next cycle: outputs return to reset values, load_data stays 0, FSM in IDLE.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per load/store over a
// valid/ready request channel, stalls the pipeline until it completes, and extends load data.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_valid,
    input  logic [31:0] MEM_inst,
    input  logic [31:0] MEM_alu_res,
    input  logic [31:0] MEM_rs2_val,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic [31:0] load_data
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] load_data_q, load_data_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store, mem_op;
    logic        funct3_legal, misaligned, fault, accept;
    logic        unused_inst_bits;

    assign opcode           = MEM_inst[6:0];
    assign funct3           = MEM_inst[14:12];
    assign unused_inst_bits = ^{MEM_inst[31:15], MEM_inst[11:7]};

    function automatic logic [31:0] store_data(input logic [31:0] rs2, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   store_data = {4{rs2[7:0]}};
            2'b01:   store_data = {2{rs2[15:0]}};
            default: store_data = rs2;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_strb = 4'b0001 << off;
            2'b01:   store_strb = 4'b0011 << off;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'b0, b};
            3'b101:  load_extend = {16'b0, h};
            default: load_extend = rdata;
        endcase
    endfunction

    always_comb begin
        is_load  = MEM_valid && (opcode == 7'b0000011);
        is_store = MEM_valid && (opcode == 7'b0100011);
        mem_op   = is_load || is_store;
        if (is_load) begin
            funct3_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else begin
            funct3_legal = funct3 inside {3'b000, 3'b001, 3'b010};
        end
        misaligned = ((funct3[1:0] == 2'b01) && MEM_alu_res[0])
                  || ((funct3[1:0] == 2'b10) && (MEM_alu_res[1:0] != 2'b00));
        fault      = mem_op && (!funct3_legal || misaligned);
        accept     = mem_op && !fault;
    end

    assign mem_fault = fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (dmem_req_ready) state_d = we_q ? DONE : WAIT;
            WAIT:    if (dmem_resp_valid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall drops in DONE so the pipeline advances exactly once per access
    always_comb begin
        dmem_req_valid = (state_q == REQ);
        mem_stall      = accept && (state_q != DONE);
    end

    always_comb begin
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        if ((state_q == IDLE) && accept) begin
            we_d     = is_store;
            addr_d   = {MEM_alu_res[31:2], 2'b00};
            wdata_d  = store_data(MEM_rs2_val, funct3);
            wstrb_d  = is_store ? store_strb(funct3, MEM_alu_res[1:0]) : 4'b0000;
            funct3_d = funct3;
            off_d    = MEM_alu_res[1:0];
        end
        if ((state_q == WAIT) && dmem_resp_valid) begin
            load_data_d = load_extend(dmem_rdata, funct3_q, off_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            load_data_q <= 32'd0;
        end else begin
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
        end
    end

    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign load_data  = load_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, reset-in-WAIT sequence, and
// randomized accesses against a byte-level reference model with a scripted memory.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_valid;
    logic [31:0] MEM_inst, MEM_alu_res, MEM_rs2_val;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_rdata;
    logic        mem_stall, mem_fault;
    logic [31:0] load_data;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst), .MEM_valid(MEM_valid), .MEM_inst(MEM_inst),
        .MEM_alu_res(MEM_alu_res), .MEM_rs2_val(MEM_rs2_val),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_resp_valid(dmem_resp_valid),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .mem_fault(mem_fault),
        .load_data(load_data)
    );

    typedef struct {
        bit          v;
        logic [31:0] inst, addr, rs2, rdata;
        int          rlat, plat;
        bit          fault, issue, we;
        logic [31:0] eaddr, wdata;
        logic [3:0]  wstrb;
        logic [31:0] load;
        int          stalls;
    } vec_t;

    typedef struct {
        bit          fault, issue, we;
        logic [31:0] addr, wdata, ld;
        logic [3:0]  wstrb;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    string       cur = "";
    logic [31:0] last_load = 32'd0;

    task automatic check(input string what, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s %s: got=%h want=%h", cur, what, got, want);
        end
    endtask

    function automatic vec_t mk(input bit v, input logic [31:0] inst, addr, rs2, rdata,
                                input int rlat, plat, input bit fault, issue, we,
                                input logic [31:0] eaddr, wdata, input logic [3:0] wstrb,
                                input logic [31:0] load, input int stalls);
        vec_t t;
        t.v = v; t.inst = inst; t.addr = addr; t.rs2 = rs2; t.rdata = rdata;
        t.rlat = rlat; t.plat = plat; t.fault = fault; t.issue = issue; t.we = we;
        t.eaddr = eaddr; t.wdata = wdata; t.wstrb = wstrb; t.load = load; t.stalls = stalls;
        return t;
    endfunction

    // Reference: access size in bytes, lane replication by modulo, extension by arithmetic
    function automatic exp_t model(input bit v, input logic [31:0] inst, addr, rs2, rdata);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        int          size, off;
        bit          isl, iss, legal;
        longint      val;
        op  = inst[6:0];
        f3  = inst[14:12];
        isl = v && (op == 7'h03);
        iss = v && (op == 7'h23);
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        legal = isl ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        off   = int'(addr % 4);
        e.fault = (isl || iss) && (!legal || (size != 0 && (off % size) != 0));
        e.issue = (isl || iss) && !e.fault;
        e.we    = iss;
        e.addr  = addr - 32'(off);
        e.wdata = 32'd0;
        e.wstrb = 4'd0;
        e.ld    = 32'd0;
        if (e.issue && iss) begin
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
            e.wstrb = 4'(((1 << size) - 1) << off);
        end
        if (e.issue && isl) begin
            val = longint'(rdata >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
            if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                val = val - (longint'(1) << (8 * size));
            e.ld = val[31:0];
        end
        return e;
    endfunction

    // Presents one MEM-stage instruction, plays memory, and checks the whole access.
    // Entered and left just after a rising edge.
    task automatic run_op(input bit v, input logic [31:0] inst, addr, rs2, rdata,
                          input int rlat, plat, input bit e_fault, e_issue, e_we,
                          input logic [31:0] e_addr, e_wdata, input logic [3:0] e_wstrb,
                          input logic [31:0] e_load, input int e_stalls);
        int          cyc = 0, stalls = 0, hs = 0, req_cnt = 0, first_req = -1, resp_at = -1;
        bit          done = 0, unstable = 0, got_fault = 0, req_at_start = 0;
        logic        p_we = 1'b0;
        logic [31:0] p_addr = 32'd0, p_wdata = 32'd0, ld = 32'd0;
        logic [3:0]  p_wstrb = 4'd0;
        MEM_valid   = v;
        MEM_inst    = inst;
        MEM_alu_res = addr;
        MEM_rs2_val = rs2;
        while (!done && cyc < 60) begin
            dmem_req_ready  = (req_cnt >= rlat);
            dmem_resp_valid = (cyc == resp_at) || (resp_at < 0 && $urandom_range(0, 2) == 0);
            dmem_rdata      = (cyc == resp_at) ? rdata : $urandom;
            @(negedge clk);
            if (cyc == 0) begin
                got_fault    = mem_fault;
                req_at_start = dmem_req_valid;
            end
            if (dmem_req_valid) begin
                if (req_cnt == 0) begin
                    first_req = cyc;
                    p_we = dmem_we; p_addr = dmem_addr; p_wdata = dmem_wdata; p_wstrb = dmem_wstrb;
                end else if ({dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== {p_we, p_addr, p_wdata, p_wstrb}) begin
                    unstable = 1;
                end
                if (dmem_req_ready) begin
                    hs++;
                    if (!e_we && resp_at < 0) resp_at = cyc + plat;
                end
                req_cnt++;
            end else if (req_cnt > 0 && hs == 0) begin
                unstable = 1;
            end
            if (mem_stall) stalls++;
            else begin
                done = 1;
                ld   = load_data;
            end
            cyc++;
            @(posedge clk); #1;
        end
        MEM_valid       = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_req_ready  = 1'b0;
        check("completed", 32'(done), 32'd1);
        check("fault", 32'(got_fault), 32'(e_fault));
        check("req_in_idle", 32'(req_at_start), 32'd0);
        check("stall_cycles", stalls, e_stalls);
        check("handshakes", hs, 32'(e_issue));
        if (e_issue) begin
            check("req_delay", first_req, 32'd1);
            check("payload_stable", 32'(unstable), 32'd0);
            check("we", 32'(p_we), 32'(e_we));
            check("addr", p_addr, e_addr);
            check("wstrb", 32'(p_wstrb), 32'(e_wstrb));
            if (e_we) check("wdata", p_wdata, e_wdata);
        end
        check("load_data", ld, e_load);
    endtask

    task automatic idle_cycles(input int n);
        MEM_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            dmem_resp_valid = ($urandom_range(0, 1) == 1);
            dmem_rdata      = $urandom;
            @(negedge clk);
            check("idle_stall", 32'(mem_stall), 32'd0);
            check("idle_req", 32'(dmem_req_valid), 32'd0);
            check("idle_load_hold", load_data, last_load);
            @(posedge clk); #1;
        end
        dmem_resp_valid = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[$];
        exp_t        e;
        logic [31:0] rnd, a, rs2, rd, inst, ld;
        logic [6:0]  opc;
        int          sel, rlat, plat, st;
        bit          v;

        rst = 1'b1; MEM_valid = 1'b0; MEM_inst = 32'd0; MEM_alu_res = 32'd0; MEM_rs2_val = 32'd0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        cur = "reset";
        @(negedge clk);
        check("req_valid", 32'(dmem_req_valid), 32'd0);
        check("we", 32'(dmem_we), 32'd0);
        check("addr", dmem_addr, 32'd0);
        check("wdata", dmem_wdata, 32'd0);
        check("wstrb", 32'(dmem_wstrb), 32'd0);
        check("load_data", load_data, 32'd0);
        check("stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //            v  inst          addr        rs2           rdata        rl pl  f  i  we eaddr       wdata         wstrb    load          st
        vecs.push_back(mk(1, 32'h00002003, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 0, 1, 0, 32'h100, 32'h0,        4'b0000, 32'hDEADBEEF, 3));
        vecs.push_back(mk(1, 32'h00000003, 32'h103, 32'h0,        32'h80FF1234, 0, 1, 0, 1, 0, 32'h100, 32'h0,        4'b0000, 32'hFFFFFF80, 3));
        vecs.push_back(mk(1, 32'h00004003, 32'h103, 32'h0,        32'h80FF1234, 0, 1, 0, 1, 0, 32'h100, 32'h0,        4'b0000, 32'h00000080, 3));
        vecs.push_back(mk(1, 32'h00005003, 32'h102, 32'h0,        32'h80FF1234, 0, 1, 0, 1, 0, 32'h100, 32'h0,        4'b0000, 32'h000080FF, 3));
        vecs.push_back(mk(1, 32'h00001003, 32'h102, 32'h0,        32'h80FF1234, 0, 1, 0, 1, 0, 32'h100, 32'h0,        4'b0000, 32'hFFFF80FF, 3));
        vecs.push_back(mk(1, 32'h00000023, 32'h201, 32'h000000AB, 32'h0,        0, 1, 0, 1, 1, 32'h200, 32'hABABABAB, 4'b0010, 32'hFFFF80FF, 2));
        vecs.push_back(mk(1, 32'h00001023, 32'h202, 32'h1234CDEF, 32'h0,        0, 1, 0, 1, 1, 32'h200, 32'hCDEFCDEF, 4'b1100, 32'hFFFF80FF, 2));
        vecs.push_back(mk(1, 32'h00002023, 32'h204, 32'hCAFEF00D, 32'h0,        5, 1, 0, 1, 1, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hFFFF80FF, 7));
        vecs.push_back(mk(1, 32'h00002003, 32'h108, 32'h0,        32'h01234567, 5, 3, 0, 1, 0, 32'h108, 32'h0,        4'b0000, 32'h01234567, 10));
        vecs.push_back(mk(1, 32'h00002003, 32'h102, 32'h0,        32'h0,        0, 1, 1, 0, 0, 32'h0,   32'h0,        4'b0000, 32'h01234567, 0));
        vecs.push_back(mk(1, 32'h00003003, 32'h100, 32'h0,        32'h0,        0, 1, 1, 0, 0, 32'h0,   32'h0,        4'b0000, 32'h01234567, 0));
        vecs.push_back(mk(1, 32'h00004023, 32'h100, 32'h0,        32'h0,        0, 1, 1, 0, 0, 32'h0,   32'h0,        4'b0000, 32'h01234567, 0));
        vecs.push_back(mk(1, 32'h00001023, 32'h203, 32'h0,        32'h0,        0, 1, 1, 0, 0, 32'h0,   32'h0,        4'b0000, 32'h01234567, 0));
        vecs.push_back(mk(0, 32'h00002003, 32'h100, 32'h0,        32'h0,        0, 1, 0, 0, 0, 32'h0,   32'h0,        4'b0000, 32'h01234567, 0));
        vecs.push_back(mk(1, 32'h00100013, 32'h100, 32'h0,        32'h0,        0, 1, 0, 0, 0, 32'h0,   32'h0,        4'b0000, 32'h01234567, 0));

        foreach (vecs[i]) begin
            cur = $sformatf("vec%0d", i);
            run_op(vecs[i].v, vecs[i].inst, vecs[i].addr, vecs[i].rs2, vecs[i].rdata,
                   vecs[i].rlat, vecs[i].plat, vecs[i].fault, vecs[i].issue, vecs[i].we,
                   vecs[i].eaddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].load, vecs[i].stalls);
        end
        last_load = 32'h01234567;

        cur = "rst_in_wait";
        MEM_valid = 1'b1; MEM_inst = 32'h00002003; MEM_alu_res = 32'h300; MEM_rs2_val = 32'd0;
        dmem_req_ready = 1'b1; dmem_resp_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("req_valid_in_req", 32'(dmem_req_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("stall_in_wait", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; MEM_valid = 1'b0; dmem_req_ready = 1'b0;
        dmem_resp_valid = 1'b1; dmem_rdata = 32'h5555AAAA;
        @(negedge clk);
        check("req_valid", 32'(dmem_req_valid), 32'd0);
        check("we", 32'(dmem_we), 32'd0);
        check("addr", dmem_addr, 32'd0);
        check("wdata", dmem_wdata, 32'd0);
        check("wstrb", 32'(dmem_wstrb), 32'd0);
        check("load_data", load_data, 32'd0);
        check("stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        dmem_resp_valid = 1'b0;
        @(negedge clk);
        check("load_data_after_resp", load_data, 32'd0);
        check("req_valid_after_resp", 32'(dmem_req_valid), 32'd0);
        @(posedge clk); #1;
        last_load = 32'd0;

        cur = "idle_resp";
        idle_cycles(4);

        for (int i = 0; i < 200; i++) begin
            rnd  = $urandom;
            sel  = int'($urandom_range(0, 9));
            opc  = (sel < 4) ? 7'h03 : (sel < 8) ? 7'h23 : (sel == 8) ? 7'h13 : rnd[6:0];
            inst = {rnd[31:15], rnd[14:12], rnd[11:7], opc};
            v    = ($urandom_range(0, 9) != 0);
            a    = $urandom;
            rs2  = $urandom;
            rd   = $urandom;
            if ($urandom_range(0, 1) == 1) a[0] = 1'b0;
            rlat = int'($urandom_range(0, 3));
            plat = int'($urandom_range(1, 3));
            e    = model(v, inst, a, rs2, rd);
            ld   = (e.issue && !e.we) ? e.ld : last_load;
            st   = e.issue ? (e.we ? 2 + rlat : 2 + rlat + plat) : 0;
            cur  = $sformatf("rnd%0d", i);
            run_op(v, inst, a, rs2, rd, rlat, plat, e.fault, e.issue, e.we,
                   e.addr, e.wdata, e.wstrb, ld, st);
            last_load = ld;
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
